// File: rtl/ipv6_packetiser_core.sv
// rtl/ipv6_packetiser_core.sv - wraps one sensor byte in a fixed IPv6 header and streams 41 bytes to the radio
//
// Purpose: latches a payload byte and emits a 40-byte IPv6 header followed by
// that byte, one byte per send strobe. Each issued byte is followed by a
// HOLD cycle. radio_busy stalls issue only.
//
// Optional feature: define IPV6_PACKETISER_SEQ_EN to replace the constant
// flow label with a 20-bit packet sequence counter.
//
// Ports:
//   clk           in   1  system clock, rising edge
//   rst           in   1  asynchronous active-high reset
//   data_in       in   8  payload byte
//   data_valid    in   1  qualifies data_in, sampled only while idle
//   radio_busy    in   1  radio cannot accept a byte this cycle
//   tx_data       out  8  registered byte presented to the radio
//   send          out  1  one-cycle strobe, tx_data valid
//   packet_valid  out  1  high for the whole packet emission
module ipv6_packetiser_core #(
  parameter logic [127:0] SRC_ADDR      = 128'hFE80_0000_0000_0000_0000_0000_0000_0001,
  parameter logic [127:0] DST_ADDR      = 128'hFE80_0000_0000_0000_0000_0000_0000_0002,
  parameter logic [7:0]   TRAFFIC_CLASS = 8'h00,
  parameter logic [19:0]  FLOW_LABEL    = 20'h00000,
  parameter logic [7:0]   NEXT_HEADER   = 8'h3B,
  parameter logic [7:0]   HOP_LIMIT     = 8'd64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       radio_busy,
  output logic [7:0] tx_data,
  output logic       send,
  output logic       packet_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  localparam logic [5:0] LAST_IDX = 6'd40;

  state_t       state, state_nxt;
  logic [5:0]   idx, idx_nxt;
  logic [7:0]   payload, payload_nxt;
  logic [7:0]   tx_data_nxt;
  logic         send_nxt;
  logic         packet_valid_nxt;
  logic [19:0]  flow;
  logic [327:0] pkt;
  logic [327:0] pkt_shift;
  logic [7:0]   cur_byte;

`ifdef IPV6_PACKETISER_SEQ_EN
  logic [19:0]  seq, seq_nxt;
  assign flow = seq;
`else
  assign flow = FLOW_LABEL;
`endif

  // Whole packet as one big-endian vector; byte idx is found by shifting it
  // to the top, so byte 0 sits in pkt[327:320].
  assign pkt = {4'h6, TRAFFIC_CLASS, flow, 16'h0001, NEXT_HEADER, HOP_LIMIT,
                SRC_ADDR, DST_ADDR, payload};
  assign pkt_shift = pkt << {idx, 3'b000};
  assign cur_byte  = pkt_shift[327:320];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= 6'd0;
      payload      <= 8'h00;
      tx_data      <= 8'h00;
      send         <= 1'b0;
      packet_valid <= 1'b0;
`ifdef IPV6_PACKETISER_SEQ_EN
      seq          <= 20'd0;
`endif
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      payload      <= payload_nxt;
      tx_data      <= tx_data_nxt;
      send         <= send_nxt;
      packet_valid <= packet_valid_nxt;
`ifdef IPV6_PACKETISER_SEQ_EN
      seq          <= seq_nxt;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (data_valid) state_nxt = ISSUE;
      ISSUE:   if (!radio_busy) state_nxt = HOLD;
      HOLD:    state_nxt = (idx == LAST_IDX) ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values; registered outputs hold by default
  always_comb begin
    idx_nxt          = idx;
    payload_nxt      = payload;
    tx_data_nxt      = tx_data;
    send_nxt         = send;
    packet_valid_nxt = packet_valid;
`ifdef IPV6_PACKETISER_SEQ_EN
    seq_nxt          = seq;
`endif
    case (state)
      IDLE: begin
        send_nxt = 1'b0;
        if (data_valid) begin
          payload_nxt      = data_in;
          idx_nxt          = 6'd0;
          packet_valid_nxt = 1'b1;
        end
      end
      ISSUE: begin
        if (!radio_busy) begin
          tx_data_nxt = cur_byte;
          send_nxt    = 1'b1;
`ifdef IPV6_PACKETISER_SEQ_EN
          // Counter advances once the last byte has left, so the flow label
          // bytes of this packet already carried the old value.
          if (idx == LAST_IDX) seq_nxt = seq + 20'd1;
`endif
        end else begin
          send_nxt = 1'b0;
        end
      end
      HOLD: begin
        send_nxt = 1'b0;
        if (idx == LAST_IDX) packet_valid_nxt = 1'b0;
        else                 idx_nxt = idx + 6'd1;
      end
      default: begin
        send_nxt         = 1'b0;
        packet_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ipv6_packetiser_core.sv
// tb/tb_ipv6_packetiser_core.sv - directed self-checking bench for ipv6_packetiser_core
module tb_ipv6_packetiser_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       radio_busy;
  logic [7:0] tx_data;
  logic       send;
  logic       packet_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx [0:63];
  int rx_n, pv_cnt, first_send, last_send, gap_bad, stall_gap, timed_out;
  logic pv_at_start;
  logic [19:0] seq_exp;

  ipv6_packetiser_core dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .radio_busy   (radio_busy),
    .tx_data      (tx_data),
    .send         (send),
    .packet_valid (packet_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a packet at the current negedge and records strobes until
  // packet_valid falls, or until stop_at bytes have been seen.
  task automatic run_packet(input logic [7:0] pl, input int stall_at, input int stall_len,
                            input int cd_cycle, input int stop_at);
    data_in    = pl;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    rx_n = 0; pv_cnt = 0; first_send = -1; last_send = -1;
    gap_bad = 0; stall_gap = -1; timed_out = 1;
    pv_at_start = packet_valid;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (packet_valid) pv_cnt++;
      if (send) begin
        rx[rx_n] = tx_data;
        if (rx_n == 0) first_send = cyc;
        else if (rx_n == stall_at) stall_gap = cyc - last_send;
        else if (cyc - last_send != 2) gap_bad++;
        last_send = cyc;
        rx_n++;
      end
      if (rx_n == stop_at && !send) begin timed_out = 0; break; end
      if (!packet_valid && pv_cnt > 0) begin timed_out = 0; break; end
      radio_busy = (rx_n == stall_at) && (cyc >= last_send + 1) && (cyc <= last_send + stall_len);
      data_valid = (cyc == cd_cycle);
      data_in    = (cyc == cd_cycle) ? 8'hCD : pl;
      @(negedge clk);
    end
    radio_busy = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic verify(input logic [7:0] pl, input logic [19:0] fl, input int stall_len);
    logic [7:0] exp [0:40];
    for (int i = 0; i < 41; i++) exp[i] = 8'h00;
    exp[0] = 8'h60; exp[1] = {4'h0, fl[19:16]}; exp[2] = fl[15:8]; exp[3] = fl[7:0];
    exp[5] = 8'h01; exp[6] = 8'h3B; exp[7] = 8'h40;
    exp[8] = 8'hFE; exp[9] = 8'h80; exp[23] = 8'h01;
    exp[24] = 8'hFE; exp[25] = 8'h80; exp[39] = 8'h02;
    exp[40] = pl;
    chk("timeout", timed_out, 0);
    chk("byte_count", rx_n, 41);
    chk("pv_at_start", pv_at_start, 1'b1);
    chk("first_send_latency", first_send, 1);
    chk("pv_cycles", pv_cnt, 82 + stall_len);
    chk("gap_errors", gap_bad, 0);
    for (int i = 0; i < 41; i++) chk($sformatf("byte%0d", i), rx[i], exp[i]);
  endtask

  function automatic logic [19:0] cur_fl();
`ifdef IPV6_PACKETISER_SEQ_EN
    return seq_exp;
`else
    return 20'h00000;
`endif
  endfunction

  initial begin
    rst = 1'b1; data_in = 8'h00; data_valid = 1'b0; radio_busy = 1'b0;
    seq_exp = 20'd0;
    repeat (3) @(negedge clk);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_send", send, 1'b0);
    chk("rst_pv", packet_valid, 1'b0);
    rst = 1'b0;

    // Idle without data_valid: nothing goes out
    begin
      int seen = 0;
      repeat (10) begin @(negedge clk); if (send || packet_valid) seen++; end
      chk("idle_no_send", seen, 0);
      chk("idle_tx_data", tx_data, 8'h00);
    end

    // P1: plain packet, payload AB
    run_packet(8'hAB, -1, 0, -1, 99);
    verify(8'hAB, cur_fl(), 0);
    seq_exp = seq_exp + 1;
    @(negedge clk);
    chk("tx_hold_after", tx_data, 8'hAB);
    chk("send_low_after", send, 1'b0);

    // P2: CD offered mid-packet must be dropped
    run_packet(8'hAB, -1, 0, 40, 99);
    verify(8'hAB, cur_fl(), 0);
    seq_exp = seq_exp + 1;

    // P3: starts in the first IDLE cycle, with a 5-cycle stall at byte 8
    run_packet(8'hCD, 8, 5, -1, 99);
    verify(8'hCD, cur_fl(), 5);
    chk("stall_gap", stall_gap, 7);
    seq_exp = seq_exp + 1;

    // P4: aborted by reset while idx=20
    run_packet(8'h5A, -1, 0, -1, 20);
    chk("abort_bytes", rx_n, 20);
    chk("abort_pv_before", packet_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_tx_data", tx_data, 8'h00);
    chk("abort_send", send, 1'b0);
    chk("abort_pv", packet_valid, 1'b0);
    seq_exp = 20'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // P5: fresh packet after abort starts at byte 0
    run_packet(8'h77, -1, 0, -1, 99);
    verify(8'h77, cur_fl(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ipv6_packetiser_core.md
# ipv6_packetiser_core

Wraps a single sensor data byte in a fixed 40-byte IPv6 header and streams the resulting 41-byte packet, one byte per `send` strobe, to the radio transmitter. It sits between the sensor sampling front end and the radio TX interface and paces its output against the radio's `radio_busy` flow control.

## Interface
- `SRC_ADDR`, 128'hFE80_0000_0000_0000_0000_0000_0000_0001: IPv6 source address; transmitted MSB first.
- `DST_ADDR`, 128'hFE80_0000_0000_0000_0000_0000_0000_0002: IPv6 destination address; transmitted MSB first.
- `TRAFFIC_CLASS`, 8'h00: traffic class field.
- `FLOW_LABEL`, 20'h00000: flow label when the sequence feature is compiled out.
- `NEXT_HEADER`, 8'h3B: next-header field.
- `HOP_LIMIT`, 8'd64: hop limit field.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high; clears all state and outputs.
- `data_in`  in  8  payload byte.
- `data_valid`  in  1  qualifies `data_in`; sampled only while idle.
- `radio_busy`  in  1  radio cannot accept a byte; stalls issue.
- `tx_data`  out  8  byte presented to the radio; registered.
- `send`  out  1  one-cycle strobe: `tx_data` is valid this cycle.
- `packet_valid`  out  1  high for the entire duration of packet emission.

## Operation
- Packet is 41 bytes, index 0..40:
  - byte0 = {4'h6, TC[7:4]}
  - byte1 = {TC[3:0], FL[19:16]}
  - byte2 = FL[15:8]
  - byte3 = FL[7:0]
  - bytes4-5 = payload length 16'h0001, big-endian
  - byte6 = NEXT_HEADER
  - byte7 = HOP_LIMIT
  - bytes8-23 = SRC_ADDR[127:0], MSB first
  - bytes24-39 = DST_ADDR, MSB first
  - byte40 = latched payload
- FSM states: IDLE, ISSUE, HOLD.
- IDLE: on `data_valid`=1, latch `data_in`, set idx=0, set `packet_valid`<=1, go to ISSUE.
- ISSUE: if `radio_busy`=0, set `tx_data`<=byte[idx] and `send`<=1, go to HOLD. Otherwise stay in ISSUE with `send`=0.
- HOLD: set `send`<=0.
  - If idx=40: set `packet_valid`<=0 and go to IDLE.
  - Otherwise: idx<=idx+1 and go to ISSUE.
- `data_valid` is ignored outside IDLE. Bytes offered mid-packet are dropped, not queued.
- idx is a 6-bit counter and never exceeds 40.
- Reset mid-packet aborts the packet immediately: state returns to IDLE and all outputs clear.

## Timing
- Reset values: `tx_data`=8'h00, `send`=0, `packet_valid`=0, FSM in IDLE, idx=0, payload register=0.
- Let `data_valid` be sampled at edge E0.
  - `packet_valid` is high from E0+1.
  - The first `send` is high from E0+2 when `radio_busy` is low.
- With no stalls, `send` pulses every 2 cycles, 41 pulses total.
- `packet_valid` falls at the edge after the last `send`, 82 cycles after rising.
- `radio_busy` is sampled only in ISSUE. Each cycle it is high delays that byte by one cycle. It has no effect in HOLD.
- `tx_data` holds its last value between strobes and after the packet ends.
- A new `data_valid` is accepted in the first IDLE cycle, i.e. the edge after `packet_valid` falls.

## Configuration
- `IPV6_PACKETISER_SEQ_EN` defined:
  - A 20-bit packet sequence counter replaces `FLOW_LABEL` in bytes1-3.
  - The counter resets to 0 and increments by 1 (mod 2^20) when byte40 is issued.
  - The first packet after reset carries 0, the second carries 1.
- Not defined: the flow label is the `FLOW_LABEL` parameter constant and no counter is built.

## Test plan
- Reset asserted, then released -> `tx_data`=00, `send`=0, `packet_valid`=0. No `send` occurs without `data_valid`.
- Defaults, `data_valid` with `data_in`=AB -> 41 strobes:
  - 60 00 00 00 00 01 3B 40
  - FE 80 00…00 01
  - FE 80 00…00 02
  - AB
  - `packet_valid` high for 82 cycles.
- `data_valid` with `data_in`=CD pulsed in the middle of a packet -> ignored; that packet's byte40 remains AB. A second packet after IDLE ends with CD.
- `radio_busy` held high 5 cycles while in ISSUE at idx=8 -> no strobe during the stall. Byte8=FE follows the cycle after `radio_busy` falls, and the byte sequence is unchanged.
- `rst` asserted at idx=20 -> outputs clear asynchronously. The next `data_valid` starts at byte0=60.
- With `IPV6_PACKETISER_SEQ_EN`, two packets -> byte3=00 in the first packet and 01 in the second.
